// File: rtl/fib_table.sv
// fib_table: FIB packet engine; inbound SPI->PIT (clk, rst, RX_valid, data_SPI_to_FIB, rejected -> pit_out_*, prefix_ready, data_FIB_to_PIT) and outbound PIT->SPI (start_send_to_pit, fib_out_bit, pit_in_*, data_PIT_to_FIB -> FIB_to_SPI_data_flag, data_FIB_to_SPI); FIB_REJECT_EN enables payload drop on rejected
module fib_table (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] pit_in_prefix,
  input  logic [7:0]  pit_in_metadata,
  input  logic        rejected,
  input  logic        fib_out_bit,
  input  logic        start_send_to_pit,
  input  logic [7:0]  data_PIT_to_FIB,
  input  logic        RX_valid,
  input  logic [7:0]  data_SPI_to_FIB,
  output logic [63:0] pit_out_prefix,
  output logic        prefix_ready,
  output logic [7:0]  pit_out_metadata,
  output logic [7:0]  data_FIB_to_PIT,
  output logic        FIB_to_SPI_data_flag,
  output logic [7:0]  data_FIB_to_SPI
);
  typedef enum logic [2:0] {I_IDLE, I_RX, I_READY, I_DECIDE, I_FWD} in_st_t;
  typedef enum logic [1:0] {O_IDLE, O_COLLECT, O_FLAG, O_TX} out_st_t;
  in_st_t ist, ist_n;
  out_st_t ost, ost_n;
  logic [5:0] icnt, ocnt;
  logic [7:0] imeta;
  logic [63:0] ipfx;
  logic [255:0] ipay;
  logic [327:0] obuf;
  logic odata, ilast, olast, rej;
`ifdef FIB_REJECT_EN
  assign rej = rejected;
`else
  logic unused_rejected;
  assign unused_rejected = rejected;
  assign rej = 1'b0;
`endif
  assign ilast = (icnt == 6'd8 && imeta[6]) || icnt == 6'd40;
  assign olast = ocnt == (odata ? 6'd40 : 6'd8);
  assign prefix_ready = ist == I_READY;
  assign data_FIB_to_PIT = ist == I_FWD ? ipay[255:248] : 8'd0;
  assign FIB_to_SPI_data_flag = ost == O_FLAG;
  always_comb begin
    ist_n = I_IDLE;
    if (RX_valid) ist_n = I_RX;
    else
      unique case (ist)
        I_RX:     ist_n = ilast ? I_READY : I_RX;
        I_READY:  ist_n = imeta[6] ? I_IDLE : I_DECIDE;
        I_DECIDE: ist_n = rej ? I_IDLE : I_FWD;
        I_FWD:    ist_n = icnt == 6'd31 ? I_IDLE : I_FWD;
        default:  ist_n = I_IDLE;
      endcase
  end
  always_comb begin
    ost_n = ost;
    unique case (ost)
      O_IDLE:    ost_n = start_send_to_pit ? (fib_out_bit ? O_COLLECT : O_FLAG) : O_IDLE;
      O_COLLECT: ost_n = ocnt == 6'd31 ? O_FLAG : O_COLLECT;
      O_FLAG:    ost_n = O_TX;
      default:   ost_n = olast ? O_IDLE : O_TX;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ist <= I_IDLE;
      icnt <= '0;
      imeta <= '0;
      ipfx <= '0;
      ipay <= '0;
      pit_out_prefix <= '0;
      pit_out_metadata <= '0;
    end else begin
      ist <= ist_n;
      icnt <= (RX_valid || ist_n != ist) ? 6'd0 : icnt + 6'd1;
      if (ist == I_RX && !RX_valid) begin
        if (icnt == 6'd0) imeta <= data_SPI_to_FIB;
        else if (icnt <= 6'd8) ipfx <= {ipfx[55:0], data_SPI_to_FIB};
        else ipay <= {ipay[247:0], data_SPI_to_FIB};
        if (ilast) begin
          pit_out_metadata <= imeta;
          pit_out_prefix <= imeta[6] ? {ipfx[55:0], data_SPI_to_FIB} : ipfx;
        end
      end
      if (ist == I_FWD) ipay <= {ipay[247:0], 8'd0};
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      ost <= O_IDLE;
      ocnt <= '0;
      odata <= 1'b0;
      obuf <= '0;
      data_FIB_to_SPI <= '0;
    end else begin
      ost <= ost_n;
      ocnt <= ost_n != ost ? 6'd0 : ocnt + 6'd1;
      if (ost == O_IDLE && start_send_to_pit) begin
        odata <= fib_out_bit;
        obuf <= {pit_in_metadata, pit_in_prefix, 256'd0};
      end
      if (ost == O_COLLECT) obuf[255:0] <= {obuf[247:0], data_PIT_to_FIB};
      if (ost == O_FLAG || (ost == O_TX && !olast)) begin
        data_FIB_to_SPI <= obuf[327:320];
        obuf <= {obuf[319:0], 8'd0};
      end
    end
  end
endmodule

// File: tb/tb_fib_table.sv
// tb_fib_table: directed table-driven checks of fib_table inbound and outbound paths
module tb_fib_table;
  logic clk = 1'b0, rst = 1'b1;
  logic [63:0] pit_in_prefix = '0;
  logic [7:0] pit_in_metadata = '0, data_PIT_to_FIB = '0, data_SPI_to_FIB = '0;
  logic rejected = 1'b0, fib_out_bit = 1'b0, start_send_to_pit = 1'b0, RX_valid = 1'b0;
  logic [63:0] pit_out_prefix;
  logic prefix_ready, FIB_to_SPI_data_flag;
  logic [7:0] pit_out_metadata, data_FIB_to_PIT, data_FIB_to_SPI;
  int tests = 0, fails = 0, pr_cnt = 0, fl_cnt = 0;
`ifdef FIB_REJECT_EN
  localparam bit REJ_EN = 1'b1;
`else
  localparam bit REJ_EN = 1'b0;
`endif
  typedef struct {
    logic [7:0]  meta;
    logic [63:0] pfx;
    logic [7:0]  exp_meta;
    logic [63:0] exp_pfx;
  } in_vec_t;
  typedef struct {
    logic [63:0] pfx;
    logic [7:0]  meta;
    logic [71:0] exp;
  } out_vec_t;
  in_vec_t iv[4];
  out_vec_t ov[2];
  fib_table dut (
    .clk(clk), .rst(rst),
    .pit_in_prefix(pit_in_prefix), .pit_in_metadata(pit_in_metadata), .rejected(rejected),
    .fib_out_bit(fib_out_bit), .start_send_to_pit(start_send_to_pit), .data_PIT_to_FIB(data_PIT_to_FIB),
    .RX_valid(RX_valid), .data_SPI_to_FIB(data_SPI_to_FIB),
    .pit_out_prefix(pit_out_prefix), .prefix_ready(prefix_ready), .pit_out_metadata(pit_out_metadata),
    .data_FIB_to_PIT(data_FIB_to_PIT), .FIB_to_SPI_data_flag(FIB_to_SPI_data_flag),
    .data_FIB_to_SPI(data_FIB_to_SPI)
  );
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (prefix_ready) pr_cnt <= pr_cnt + 1;
    if (FIB_to_SPI_data_flag) fl_cnt <= fl_cnt + 1;
  end
  task automatic chk(input string nm, input logic [71:0] act, input logic [71:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic send_int(input in_vec_t v);
    int p0;
    p0 = pr_cnt;
    RX_valid = 1'b1;
    tick();
    RX_valid = 1'b0;
    data_SPI_to_FIB = v.meta;
    tick();
    for (int k = 0; k < 8; k++) begin
      data_SPI_to_FIB = v.pfx[63-8*k -: 8];
      tick();
    end
    chk("int_ready", 72'(prefix_ready), 72'd1);
    chk("int_meta", 72'(pit_out_metadata), 72'(v.exp_meta));
    chk("int_prefix", 72'(pit_out_prefix), 72'(v.exp_pfx));
    chk("int_pit_data", 72'(data_FIB_to_PIT), 72'd0);
    data_SPI_to_FIB = 8'h00;
    tick();
    chk("int_ready_low", 72'(prefix_ready), 72'd0);
    chk("int_pulses", 72'(pr_cnt - p0), 72'd1);
    chk("int_pit_data_after", 72'(data_FIB_to_PIT), 72'd0);
    chk("int_prefix_hold", 72'(pit_out_prefix), 72'(v.exp_pfx));
  endtask
  task automatic send_data(input logic rej, input logic exp_fwd);
    logic [7:0] pay[32];
    logic [63:0] pfx;
    string s;
    int bad;
    s = "this is an example";
    pfx = 64'h0000FFFF0000FFFF;
    bad = 0;
    for (int i = 0; i < 32; i++) pay[i] = i < 14 ? 8'h00 : 8'(s[i-14]);
    RX_valid = 1'b1;
    tick();
    RX_valid = 1'b0;
    data_SPI_to_FIB = 8'h30;
    tick();
    for (int k = 0; k < 8; k++) begin
      data_SPI_to_FIB = pfx[63-8*k -: 8];
      tick();
    end
    for (int i = 0; i < 32; i++) begin
      chk("data_no_early_ready", 72'(prefix_ready), 72'd0);
      data_SPI_to_FIB = pay[i];
      tick();
    end
    data_SPI_to_FIB = 8'h00;
    rejected = rej;
    chk("data_ready", 72'(prefix_ready), 72'd1);
    chk("data_meta", 72'(pit_out_metadata), 72'h30);
    chk("data_prefix", 72'(pit_out_prefix), 72'(pfx));
    tick();
    chk("decide_ready_low", 72'(prefix_ready), 72'd0);
    chk("decide_pit_data", 72'(data_FIB_to_PIT), 72'd0);
    tick();
    rejected = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("fwd_byte", 72'(data_FIB_to_PIT), exp_fwd ? 72'(pay[i]) : 72'd0);
      tick();
    end
    chk("fwd_end_zero", 72'(data_FIB_to_PIT), 72'd0);
    for (int i = 0; i < 252; i++) begin
      if (data_FIB_to_PIT !== 8'd0 || prefix_ready !== 1'b0) bad++;
      tick();
    end
    chk("extra_bytes_quiet", 72'(bad), 72'd0);
  endtask
  task automatic send_out(input out_vec_t v);
    int f0;
    f0 = fl_cnt;
    pit_in_prefix = v.pfx;
    pit_in_metadata = v.meta;
    fib_out_bit = 1'b0;
    start_send_to_pit = 1'b1;
    tick();
    start_send_to_pit = 1'b0;
    chk("oint_flag", 72'(FIB_to_SPI_data_flag), 72'd1);
    for (int k = 0; k < 9; k++) begin
      tick();
      chk("oint_byte", 72'(data_FIB_to_SPI), 72'(v.exp[71-8*k -: 8]));
    end
    tick();
    chk("oint_hold", 72'(data_FIB_to_SPI), 72'(v.exp[7:0]));
    chk("oint_flag_pulses", 72'(fl_cnt - f0), 72'd1);
  endtask
  initial begin
    int f0, p0, bad;
    iv[0] = '{8'h70, 64'h0000FFFF0000FFFF, 8'h70, 64'h0000FFFF0000FFFF};
    iv[1] = '{8'h40, 64'h0123456789ABCDEF, 8'h40, 64'h0123456789ABCDEF};
    iv[2] = '{8'hFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF, 64'hFFFFFFFFFFFFFFFF};
    iv[3] = '{8'h50, 64'h8000000000000001, 8'h50, 64'h8000000000000001};
    ov[0] = '{64'h0123456789ABCDEF, 8'h70, 72'h700123456789ABCDEF};
    ov[1] = '{64'hFEDCBA9876543210, 8'h55, 72'h55FEDCBA9876543210};
    tick();
    tick();
    chk("rst_prefix", 72'(pit_out_prefix), 72'd0);
    chk("rst_meta", 72'(pit_out_metadata), 72'd0);
    chk("rst_ready", 72'(prefix_ready), 72'd0);
    chk("rst_pit_data", 72'(data_FIB_to_PIT), 72'd0);
    chk("rst_flag", 72'(FIB_to_SPI_data_flag), 72'd0);
    chk("rst_spi_data", 72'(data_FIB_to_SPI), 72'd0);
    rst = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) send_int(iv[i]);
    send_data(1'b0, 1'b1);
    send_data(1'b1, !REJ_EN);
    for (int i = 0; i < 2; i++) send_out(ov[i]);
    f0 = fl_cnt;
    pit_in_prefix = 64'h0123456789ABCDEF;
    pit_in_metadata = 8'h30;
    fib_out_bit = 1'b1;
    start_send_to_pit = 1'b1;
    tick();
    start_send_to_pit = 1'b0;
    for (int i = 0; i < 32; i++) begin
      chk("odata_no_early_flag", 72'(FIB_to_SPI_data_flag), 72'd0);
      data_PIT_to_FIB = 8'(i);
      tick();
    end
    data_PIT_to_FIB = 8'h00;
    pit_in_metadata = 8'h70;
    fib_out_bit = 1'b0;
    chk("odata_flag", 72'(FIB_to_SPI_data_flag), 72'd1);
    for (int k = 0; k < 41; k++) begin
      start_send_to_pit = k == 5;
      tick();
      chk("odata_byte", 72'(data_FIB_to_SPI),
          k == 0 ? 72'h30 : k <= 8 ? 72'(pit_in_prefix[71-8*k -: 8]) : 72'(k - 9));
    end
    start_send_to_pit = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    chk("odata_hold", 72'(data_FIB_to_SPI), 72'h1F);
    chk("odata_restart_ignored", 72'(fl_cnt - f0), 72'd1);
    RX_valid = 1'b1;
    tick();
    RX_valid = 1'b0;
    data_SPI_to_FIB = 8'h30;
    tick();
    for (int k = 0; k < 19; k++) begin
      data_SPI_to_FIB = 8'hA5;
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    p0 = pr_cnt;
    chk("mid_rst_prefix", 72'(pit_out_prefix), 72'd0);
    chk("mid_rst_meta", 72'(pit_out_metadata), 72'd0);
    chk("mid_rst_ready", 72'(prefix_ready), 72'd0);
    chk("mid_rst_pit_data", 72'(data_FIB_to_PIT), 72'd0);
    chk("mid_rst_flag", 72'(FIB_to_SPI_data_flag), 72'd0);
    chk("mid_rst_spi_data", 72'(data_FIB_to_SPI), 72'd0);
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      data_SPI_to_FIB = 8'hA5;
      tick();
      if (prefix_ready !== 1'b0 || data_FIB_to_PIT !== 8'd0) bad++;
    end
    data_SPI_to_FIB = 8'h00;
    chk("mid_rst_discard", 72'(bad), 72'd0);
    chk("mid_rst_no_ready", 72'(pr_cnt - p0), 72'd0);
    send_int(iv[0]);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
